ahb_master_arbiter: RTL

- Shares the single AHB slave port of the AHB-to-APB bridge between up to MASTERS AHB masters.
- Round-robin arbitration among requesters, honouring locked transfers and a maximum tenure.
- Muxes the address/control phase by the current owner and the write-data phase by the previous owner (AHB pipeline).
- Sits between the masters and the bridge top-level, driving its Htrans/Haddr/Hwrite/Hsize/Hwdata/Hready_in and consuming its Hready_out.

---
 rtl/ahb_master_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/ahb_master_arbiter.sv
// Round-robin AHB master arbiter in front of the AHB-to-APB bridge slave port.
// Address/control is muxed by the current owner; write data by the data-phase owner.
module ahb_master_arbiter #(
  parameter int MASTERS = 4,
  parameter int WIDTH   = 32,
  parameter int TENURE  = 8,
  parameter int MW      = 2
) (
  input  logic                       Hclk,
  input  logic                       Hreset,
  input  logic [MASTERS-1:0]         Hbusreq,
  input  logic [MASTERS-1:0]         Hlock,
  input  logic [2*MASTERS-1:0]       Htrans_m,
  input  logic [WIDTH*MASTERS-1:0]   Haddr_m,
  input  logic [MASTERS-1:0]         Hwrite_m,
  input  logic [3*MASTERS-1:0]       Hsize_m,
  input  logic [WIDTH*MASTERS-1:0]   Hwdata_m,
  input  logic                       Hready,
  output logic [MASTERS-1:0]         Hgrant,
  output logic [MW-1:0]              Hmaster,
  output logic [MW-1:0]              Hmaster_d,
  output logic [1:0]                 Htrans,
  output logic [WIDTH-1:0]           Haddr,
  output logic                       Hwrite,
  output logic [2:0]                 Hsize,
  output logic [WIDTH-1:0]           Hwdata,
  output logic                       Hready_in
);

  localparam int CW = $clog2(TENURE + 1);

  typedef enum logic [1:0] {PARK, OWN, LOCK} state_t;

  state_t           state_reg, state_next;
  logic [MW-1:0]    master_reg, master_next;
  logic [MW-1:0]    master_d_reg;
  logic [CW-1:0]    cnt_reg, cnt_next;

  logic [1:0]       trans_a [MASTERS];
  logic [WIDTH-1:0] addr_a  [MASTERS];
  logic [WIDTH-1:0] wdata_a [MASTERS];
  logic [2:0]       size_a  [MASTERS];

  genvar gi;
  generate
    for (gi = 0; gi < MASTERS; gi++) begin : g_unpack
      assign trans_a[gi] = Htrans_m[2*gi +: 2];
      assign addr_a[gi]  = Haddr_m[WIDTH*gi +: WIDTH];
      assign wdata_a[gi] = Hwdata_m[WIDTH*gi +: WIDTH];
      assign size_a[gi]  = Hsize_m[3*gi +: 3];
      assign Hgrant[gi]  = (master_reg == MW'(gi));
    end
  endgenerate

  logic [1:0]    own_trans;
  logic          own_req, own_lock, own_idle, own_nonseq, others_req;
  logic          win_valid, tenure_hit;
  logic [MW-1:0] win_idx, cand;

  assign own_trans  = trans_a[master_reg];
  assign own_req    = Hbusreq[master_reg];
  assign own_lock   = Hlock[master_reg] & own_req;
  assign own_idle   = (own_trans == 2'b00);
  assign own_nonseq = (own_trans == 2'b10);
  assign others_req = |(Hbusreq & ~Hgrant);

  // Scan downward so the closest index after the owner wins; the owner itself is last.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = MASTERS; k >= 1; k--) begin
      cand = MW'((int'(master_reg) + k) % MASTERS);
      if (Hbusreq[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    master_next = master_reg;
    cnt_next    = cnt_reg;
    tenure_hit  = 1'b0;
    case (state_reg)
      PARK: begin
        if (win_valid) begin
          master_next = win_idx;
          cnt_next    = '0;
          state_next  = Hlock[win_idx] ? LOCK : OWN;
        end
      end
      OWN, LOCK: begin
        if (!(state_reg == LOCK && own_lock)) begin
          // A just-released lock starts a fresh tenure, so only the idle rule can fire.
          tenure_hit = (state_reg == OWN) && (cnt_reg >= CW'(TENURE)) && others_req &&
                       (own_idle || own_nonseq);
          if ((!own_req && own_idle) || tenure_hit) begin
            cnt_next = '0;
            if (win_valid) begin
              master_next = win_idx;
              state_next  = Hlock[win_idx] ? LOCK : OWN;
            end else begin
              state_next = PARK;
            end
          end else begin
            state_next = OWN;
            if (state_reg == LOCK)
              cnt_next = '0;
            else if (own_trans[1] && (cnt_reg < CW'(TENURE)))
              cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      default: state_next = PARK;
    endcase
  end

  // Wait states freeze the whole arbitration state, including the data-phase owner.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state_reg    <= PARK;
      master_reg   <= '0;
      master_d_reg <= '0;
      cnt_reg      <= '0;
    end else if (Hready) begin
      state_reg    <= state_next;
      master_reg   <= master_next;
      master_d_reg <= master_reg;
      cnt_reg      <= cnt_next;
    end
  end

  assign Hmaster   = master_reg;
  assign Hmaster_d = master_d_reg;
  assign Htrans    = Hreset ? 2'b00 : own_trans;
  assign Haddr     = addr_a[master_reg];
  assign Hwrite    = Hwrite_m[master_reg];
  assign Hsize     = size_a[master_reg];
  assign Hwdata    = wdata_a[master_d_reg];
  assign Hready_in = Hready;

endmodule
